// File: rtl/dma_axi_pkg.sv
// Shared AXI constants and one-hot FSM state encodings for the DMA AXI bridge.
package dma_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    RIdle = 3'b001,
    RAddr = 3'b010,
    RData = 3'b100
  } rd_state_e;

  typedef enum logic [3:0] {
    WIdle = 4'b0001,
    WAddr = 4'b0010,
    WData = 4'b0100,
    WResp = 4'b1000
  } wr_state_e;

endpackage

// File: rtl/dma_axi_bridge_if.sv
// AXI4 master-side bus (AR/R/AW/W/B) between the DMA bridge and the interconnect.
interface dma_axi_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dma_axi_wr_chan.sv
// Write channel of the DMA AXI bridge: AW issue, beat-counted W stream, B wait.
module dma_axi_wr_chan
  import dma_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [4:0]            wr_req_len,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  wr_state_e             state_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  awvalid_q;
  logic [4:0]            cnt_q;
  logic                  in_data;

  assign in_data = (state_q == WData);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WIdle;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        WIdle: if (wr_req_valid) begin
          awaddr_q  <= wr_req_addr;
          awlen_q   <= {3'b000, wr_req_len};
          cnt_q     <= '0;
          awvalid_q <= 1'b1;
          state_q   <= WAddr;
        end
        WAddr: if (awready) begin
          awvalid_q <= 1'b0;
          state_q   <= WData;
        end
        WData: if (wvalid && wready) begin
          cnt_q <= cnt_q + 5'd1;
          if (wlast) state_q <= WResp;
        end
        WResp: if (bvalid) state_q <= WIdle;
        default: begin
          awvalid_q <= 1'b0;
          state_q   <= WIdle;
        end
      endcase
    end
  end

  // The engine's own last marker is ignored here; the burst ends by count.
  assign wlast        = in_data && (cnt_q == awlen_q[4:0]);
  assign wvalid       = in_data && wr_valid;
  assign wr_ready     = in_data && wready;
  assign wdata        = wr_data;
  assign bready       = (state_q == WResp);
  assign wr_req_ready = (state_q == WIdle);
  assign awaddr       = awaddr_q;
  assign awlen        = awlen_q;
  assign awvalid      = awvalid_q;

endmodule

// File: rtl/dma_axi_bridge.sv
// DMA engine burst channels to AXI4 master bridge; independent read and write FSMs.
// Optional sticky error capture when DMA_BRIDGE_ERR_EN is defined.
module dma_axi_bridge
  import dma_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [4:0]            rd_req_len,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [4:0]            wr_req_len,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  dma_axi_bridge_if.master      axi
`ifdef DMA_BRIDGE_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  err_flag,
  output logic                  err_src,
  output logic [ADDR_WIDTH-1:0] err_addr
`endif
);

  rd_state_e             rd_state_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic                  arvalid_q;
  logic                  rd_in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RIdle;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
    end else begin
      unique case (rd_state_q)
        RIdle: if (rd_req_valid) begin
          araddr_q   <= rd_req_addr;
          arlen_q    <= {3'b000, rd_req_len};
          arvalid_q  <= 1'b1;
          rd_state_q <= RAddr;
        end
        RAddr: if (axi.arready) begin
          arvalid_q  <= 1'b0;
          rd_state_q <= RData;
        end
        RData: if (axi.rvalid && rd_ready && axi.rlast) rd_state_q <= RIdle;
        default: begin
          arvalid_q  <= 1'b0;
          rd_state_q <= RIdle;
        end
      endcase
    end
  end

  assign rd_in_data   = (rd_state_q == RData);
  assign rd_req_ready = (rd_state_q == RIdle);
  assign rd_rdata     = axi.rdata;
  assign rd_valid     = rd_in_data && axi.rvalid;
  assign rd_last      = rd_in_data && axi.rlast;
  assign axi.rready   = rd_in_data && rd_ready;
  assign axi.araddr   = araddr_q;
  assign axi.arlen    = arlen_q;
  assign axi.arvalid  = arvalid_q;
  assign axi.arsize   = AXI_SIZE_4B;
  assign axi.arburst  = AXI_BURST_INCR;
  assign axi.awsize   = AXI_SIZE_4B;
  assign axi.awburst  = AXI_BURST_INCR;
  assign axi.wstrb    = '1;

  dma_axi_wr_chan #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_chan (
    .clk          (clk),
    .rst          (rst),
    .wr_req_addr  (wr_req_addr),
    .wr_req_len   (wr_req_len),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .awaddr       (axi.awaddr),
    .awlen        (axi.awlen),
    .awvalid      (axi.awvalid),
    .awready      (axi.awready),
    .wdata        (axi.wdata),
    .wlast        (axi.wlast),
    .wvalid       (axi.wvalid),
    .wready       (axi.wready),
    .bvalid       (axi.bvalid),
    .bready       (axi.bready)
  );

`ifdef DMA_BRIDGE_ERR_EN
  logic                  rd_err, wr_err, new_err;
  logic                  err_flag_q, err_src_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  assign rd_err  = rd_in_data && axi.rvalid && axi.rready && (axi.rresp != AXI_RESP_OKAY);
  assign wr_err  = (axi.bvalid && axi.bready && (axi.bresp != AXI_RESP_OKAY)) ||
                   (axi.wvalid && axi.wready && (wr_last != axi.wlast));
  assign new_err = rd_err || wr_err;

  // A fresh error beats a simultaneous clear; otherwise the first error is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag_q <= 1'b0;
      err_src_q  <= 1'b0;
      err_addr_q <= '0;
    end else if (new_err && (!err_flag_q || err_clr)) begin
      err_flag_q <= 1'b1;
      err_src_q  <= !rd_err;
      err_addr_q <= rd_err ? araddr_q : axi.awaddr;
    end else if (err_clr) begin
      err_flag_q <= 1'b0;
      err_src_q  <= 1'b0;
      err_addr_q <= '0;
    end
  end

  assign err_flag = err_flag_q;
  assign err_src  = err_src_q;
  assign err_addr = err_addr_q;
`else
  logic unused_resp;
  assign unused_resp = ^{wr_last, axi.rresp, axi.bresp};
`endif

endmodule

// File: tb/tb_dma_axi_bridge.sv
// Directed self-checking bench for dma_axi_bridge; bench acts as the AXI slave.
// Error-capture checks run when DMA_BRIDGE_ERR_EN is defined.
module tb_dma_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_req_addr, wr_req_addr, rd_rdata, wr_data;
  logic [4:0]  rd_req_len, wr_req_len;
  logic        rd_req_valid, rd_req_ready, rd_last, rd_valid, rd_ready;
  logic        wr_req_valid, wr_req_ready, wr_valid, wr_last, wr_ready;
`ifdef DMA_BRIDGE_ERR_EN
  logic        err_clr, err_flag, err_src;
  logic [31:0] err_addr;
`endif

  int n_pass  = 0;
  int n_total = 0;

  dma_axi_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  dma_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_addr  (rd_req_addr),
    .rd_req_len   (rd_req_len),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_rdata     (rd_rdata),
    .rd_last      (rd_last),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_len   (wr_req_len),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_last      (wr_last),
    .wr_ready     (wr_ready),
    .axi          (axi)
`ifdef DMA_BRIDGE_ERR_EN
    ,
    .err_clr      (err_clr),
    .err_flag     (err_flag),
    .err_src      (err_src),
    .err_addr     (err_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int ri, wi, cyc;
    logic rh, wh, bh, wdone, bpend;

    rst = 1'b1;
    rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0; rd_ready = 1'b0;
    wr_req_addr = '0; wr_req_len = '0; wr_req_valid = 1'b0;
    wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
    axi.arready = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bresp = '0; axi.bvalid = 1'b0;
`ifdef DMA_BRIDGE_ERR_EN
    err_clr = 1'b0;
`endif
    tick(); tick();

    // Reset state
    chkb("rst_rd_req_ready", rd_req_ready, 1'b1);
    chkb("rst_wr_req_ready", wr_req_ready, 1'b1);
    chkb("rst_arvalid", axi.arvalid, 1'b0);
    chkb("rst_awvalid", axi.awvalid, 1'b0);
    chkb("rst_rready", axi.rready, 1'b0);
    chkb("rst_bready", axi.bready, 1'b0);
    chkb("rst_wvalid", axi.wvalid, 1'b0);
    chkb("rst_wlast", axi.wlast, 1'b0);
    chk("rst_araddr", axi.araddr, 32'h0);
    chk("rst_awaddr", axi.awaddr, 32'h0);
    chk("rst_arlen", 32'(axi.arlen), 32'd0);
    chk("wstrb", 32'(axi.wstrb), 32'hF);
    rst = 1'b0;

    // Read burst 0x1000 len 7, arready delayed
    rd_req_addr = 32'h1000; rd_req_len = 5'd7; rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    chk("ar_addr", axi.araddr, 32'h1000);
    chk("ar_len", 32'(axi.arlen), 32'd7);
    chk("ar_size", 32'(axi.arsize), 32'd2);
    chk("ar_burst", 32'(axi.arburst), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chkb("ar_valid_held", axi.arvalid, 1'b1);
      chkb("rd_req_ready_busy", rd_req_ready, 1'b0);
      if (i == 2) axi.arready = 1'b1;
      tick();
    end
    axi.arready = 1'b0;
    chkb("ar_valid_drop", axi.arvalid, 1'b0);
    ri = 0;
    for (cyc = 0; cyc < 40 && ri < 8; cyc++) begin
      axi.rvalid = 1'b1; axi.rdata = 32'hA000_0000 + 32'(ri); axi.rlast = (ri == 7);
      rd_ready = cyc[0];
      #1;
      chkb("rd_valid", rd_valid, 1'b1);
      chk("rd_rdata", rd_rdata, 32'hA000_0000 + 32'(ri));
      chkb("rd_last", rd_last, ri == 7);
      chkb("rready_pass", axi.rready, cyc[0]);
      chkb("rd_req_ready_data", rd_req_ready, 1'b0);
      rh = rd_ready;
      tick();
      if (rh) ri++;
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0;
    chk("rd_beats", 32'(ri), 32'd8);
    chkb("rd_req_ready_done", rd_req_ready, 1'b1);
    chkb("rready_idle", axi.rready, 1'b0);

    // Write burst 0x2000 len 7
    wr_req_addr = 32'h2000; wr_req_len = 5'd7; wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0;
    wr_valid = 1'b1; axi.wready = 1'b1;
    #1;
    chkb("aw_valid", axi.awvalid, 1'b1);
    chk("aw_addr", axi.awaddr, 32'h2000);
    chk("aw_len", 32'(axi.awlen), 32'd7);
    chkb("w_before_aw", axi.wvalid, 1'b0);
    chkb("wr_ready_before_aw", wr_ready, 1'b0);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_data = 32'hB000_0000 + 32'(i); wr_last = (i == 7);
      #1;
      chkb("wvalid", axi.wvalid, 1'b1);
      chk("wdata", axi.wdata, 32'hB000_0000 + 32'(i));
      chkb("wlast", axi.wlast, i == 7);
      chkb("wr_ready", wr_ready, 1'b1);
      tick();
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    chkb("bready_resp", axi.bready, 1'b1);
    chkb("wvalid_resp", axi.wvalid, 1'b0);
    chkb("wr_req_ready_resp", wr_req_ready, 1'b0);
    tick();
    chkb("wr_req_ready_bwait", wr_req_ready, 1'b0);
    axi.bvalid = 1'b1;
    tick();
    axi.bvalid = 1'b0;
    chkb("wr_req_ready_after_b", wr_req_ready, 1'b1);
    chkb("bready_idle", axi.bready, 1'b0);

    // Concurrent read and write with interleaved stalls
    rd_req_addr = 32'h4000; rd_req_len = 5'd7; rd_req_valid = 1'b1;
    wr_req_addr = 32'h5000; wr_req_len = 5'd7; wr_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    axi.arready = 1'b1; axi.awready = 1'b1;
    tick();
    axi.arready = 1'b0; axi.awready = 1'b0;
    ri = 0; wi = 0; wdone = 1'b0; bpend = 1'b0;
    for (cyc = 0; cyc < 80 && !(ri == 8 && wdone); cyc++) begin
      axi.rvalid = (ri < 8) && (cyc % 3 != 0);
      axi.rdata = 32'hC000_0000 + 32'(ri); axi.rlast = (ri == 7); rd_ready = 1'b1;
      wr_valid = (wi < 8); wr_data = 32'hD000_0000 + 32'(wi); wr_last = (wi == 7);
      axi.wready = (cyc % 2 == 0);
      axi.bvalid = bpend;
      #1;
      rh = axi.rvalid && axi.rready;
      wh = axi.wvalid && axi.wready;
      bh = axi.bvalid && axi.bready;
      if (rh) chk("cc_rdata", rd_rdata, 32'hC000_0000 + 32'(ri));
      if (wh) begin
        chk("cc_wdata", axi.wdata, 32'hD000_0000 + 32'(wi));
        chkb("cc_wlast", axi.wlast, wi == 7);
      end
      tick();
      if (rh) ri++;
      if (wh) wi++;
      if (wh && wi == 8) bpend = 1'b1;
      if (bh) begin bpend = 1'b0; wdone = 1'b1; end
    end
    axi.rvalid = 1'b0; axi.bvalid = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; axi.rlast = 1'b0;
    chk("cc_rd_beats", 32'(ri), 32'd8);
    chk("cc_wr_beats", 32'(wi), 32'd8);
    chkb("cc_b_done", wdone, 1'b1);
    chkb("cc_rd_idle", rd_req_ready, 1'b1);
    chkb("cc_wr_idle", wr_req_ready, 1'b1);

    // Reset during W_DATA beat 4
    wr_req_addr = 32'h6000; wr_req_len = 5'd7; wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0; axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0; wr_valid = 1'b1; axi.wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hE000_0000 + 32'(i);
      tick();
    end
    chkb("pre_rst_wvalid", axi.wvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chkb("mid_rst_wvalid", axi.wvalid, 1'b0);
    chkb("mid_rst_awvalid", axi.awvalid, 1'b0);
    chkb("mid_rst_wr_req_ready", wr_req_ready, 1'b1);
    chkb("mid_rst_wlast", axi.wlast, 1'b0);
    wr_valid = 1'b0;

    // Fresh single-beat burst after reset
    wr_req_addr = 32'h7000; wr_req_len = 5'd0; wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0;
    chk("fresh_awaddr", axi.awaddr, 32'h7000);
    chk("fresh_awlen", 32'(axi.awlen), 32'd0);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0; wr_valid = 1'b1; wr_last = 1'b1; wr_data = 32'h1234_5678;
    #1;
    chkb("fresh_wlast", axi.wlast, 1'b1);
    chk("fresh_wdata", axi.wdata, 32'h1234_5678);
    tick();
    wr_valid = 1'b0; wr_last = 1'b0; axi.bvalid = 1'b1;
    #1;
    chkb("fresh_bready", axi.bready, 1'b1);
    tick();
    axi.bvalid = 1'b0;
    chkb("fresh_done", wr_req_ready, 1'b1);

`ifdef DMA_BRIDGE_ERR_EN
    chkb("err_init", err_flag, 1'b0);
    wr_req_addr = 32'h3000; wr_req_len = 5'd0; wr_req_valid = 1'b1;
    tick();
    wr_req_valid = 1'b0; axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0; wr_valid = 1'b1; wr_last = 1'b1; axi.wready = 1'b1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b10;
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    chkb("err_flag_b", err_flag, 1'b1);
    chkb("err_src_b", err_src, 1'b1);
    chk("err_addr_b", err_addr, 32'h3000);
    rd_req_addr = 32'h8000; rd_req_len = 5'd0; rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0; axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rresp = 2'b10;
    rd_ready = 1'b1;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; rd_ready = 1'b0;
    chkb("err_flag_keep", err_flag, 1'b1);
    chkb("err_src_keep", err_src, 1'b1);
    chk("err_addr_keep", err_addr, 32'h3000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chkb("err_flag_clr", err_flag, 1'b0);
    chkb("err_src_clr", err_src, 1'b0);
    chk("err_addr_clr", err_addr, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
